// File: rtl/triangle_fetch_if.sv
// Word-stream and held-triangle bundle between a triangle source and the vertex stage.
// master: the word source / stall driver; slave: triangle_fetch itself.
interface triangle_fetch_if #(
    parameter int CNT_W = 16
);
    logic [31:0]       word_in;
    logic              word_valid;
    logic              frame_end;
    logic              word_ready;
    logic              stall_in;
    logic [14:0][31:0] v_out;
    logic [23:0]       color_out1;
    logic [23:0]       color_out2;
    logic [23:0]       color_out3;
    logic              data_valid;
    logic              done_out;
    logic [CNT_W-1:0]  tri_count;

    modport master (
        output word_in, word_valid, frame_end, stall_in,
        input  word_ready, v_out, color_out1, color_out2, color_out3,
               data_valid, done_out, tri_count
    );

    modport slave (
        input  word_in, word_valid, frame_end, stall_in,
        output word_ready, v_out, color_out1, color_out2, color_out3,
               data_valid, done_out, tri_count
    );
endinterface

// File: rtl/triangle_fetch.sv
// Assembles 15-word triangles into a held output register; data_valid one cycle after word 14.
// A second complete triangle parks in the assembly buffer and drops word_ready until the held one leaves.
module triangle_fetch #(
    parameter int TRI_WORDS = 15,
    parameter int CNT_W     = 16
) (
    input  logic          clock,
    input  logic          reset,
    triangle_fetch_if.slave tf
);
    localparam int LAST = TRI_WORDS - 1;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        FULL     = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [3:0]                  idx;
    logic [TRI_WORDS-1:0][31:0]  abuf;
    logic [TRI_WORDS-1:0][31:0]  obuf;
    logic                        a_done;
    logic                        o_done;
    logic                        o_vld;
    logic [CNT_W-1:0]            cnt;
    logic                        ready;
    logic                        accept;
    logic                        last;
    logic                        xfer;
    logic                        direct;

    assign accept = tf.word_valid & ready;
    assign last   = accept && (idx == 4'(LAST));
    assign xfer   = o_vld & ~tf.stall_in;
    // A finished triangle bypasses the buffer whenever the output slot frees on this same edge.
    assign direct = last && (!o_vld || xfer);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ASSEMBLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ASSEMBLE: if (last && !direct) state_nxt = FULL;
            FULL:     if (xfer)            state_nxt = ASSEMBLE;
            default:                       state_nxt = ASSEMBLE;
        endcase
    end

    // Ready decodes only the state register, so stall_in never reaches word_ready combinationally.
    always_comb begin
        ready = 1'b0;
        if (state == ASSEMBLE) ready = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            abuf   <= '0;
            obuf   <= '0;
            a_done <= 1'b0;
            o_done <= 1'b0;
            o_vld  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                abuf[idx] <= tf.word_in;
                idx       <= last ? 4'd0 : idx + 4'd1;
            end
            if (last) begin
                if (direct) begin
                    obuf   <= {tf.word_in, abuf[LAST-1:0]};
                    o_done <= tf.frame_end;
                    o_vld  <= 1'b1;
                end else begin
                    a_done <= tf.frame_end;
                end
            end else if (state == FULL && xfer) begin
                obuf   <= abuf;
                o_done <= a_done;
            end else if (xfer) begin
                o_vld  <= 1'b0;
                o_done <= 1'b0;
            end
            if (xfer) cnt <= cnt + 1'b1;
        end
    end

    assign tf.word_ready = ready;
    assign tf.v_out      = obuf;
    assign tf.color_out1 = obuf[3][23:0];
    assign tf.color_out2 = obuf[7][23:0];
    assign tf.color_out3 = obuf[11][23:0];
    assign tf.data_valid = o_vld;
    assign tf.done_out   = o_done;
    assign tf.tri_count  = cnt;
endmodule

// File: tb/tb_triangle_fetch.sv
// Bench for triangle_fetch: vector table, hand sequences, random traffic against a queue model.
module tb_triangle_fetch;
    localparam int CW = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    triangle_fetch_if #(.CNT_W(CW)) tf ();

    triangle_fetch #(.TRI_WORDS(15), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .tf    (tf)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(string name, logic [14:0][31:0] act, logic [14:0][31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending words, one held triangle, at most one waiting triangle.
    logic [31:0]       m_q[$];
    logic [14:0][31:0] m_hw, m_ww, m_t;
    bit                m_hv, m_hd, m_wv, m_wd, m_xfer, m_acc, m_formed;
    logic [CW-1:0]     m_cnt;

    task automatic model_reset();
        m_q.delete();
        m_hv = 0; m_hd = 0; m_wv = 0; m_wd = 0;
        m_cnt = '0;
    endtask

    task automatic model_step();
        m_xfer   = m_hv && !tf.stall_in;
        m_acc    = tf.word_valid && !m_wv;
        m_formed = 0;
        if (m_acc) begin
            m_q.push_back(tf.word_in);
            if (m_q.size() == 15) begin
                for (int k = 0; k < 15; k++) m_t[k] = m_q[k];
                m_q.delete();
                m_formed = 1;
            end
        end
        if (m_formed && (!m_hv || m_xfer)) begin
            m_hw = m_t; m_hd = tf.frame_end; m_hv = 1;
        end else if (m_formed) begin
            m_ww = m_t; m_wd = tf.frame_end; m_wv = 1;
        end else if (m_xfer) begin
            if (m_wv) begin
                m_hw = m_ww; m_hd = m_wd; m_wv = 0;
            end else begin
                m_hv = 0; m_hd = 0;
            end
        end
        if (m_xfer) m_cnt = m_cnt + 1'b1;
    endtask

    always begin
        @(posedge clock or negedge reset);
        if (!reset) model_reset();
        else        model_step();
    end

    always @(negedge clock) begin
        if (reset && mon_en) begin
            chk("mon_valid", 32'(tf.data_valid), 32'(m_hv));
            chk("mon_ready", 32'(tf.word_ready), 32'(!m_wv));
            chk("mon_count", 32'(tf.tri_count), 32'(m_cnt));
            chk("mon_done",  32'(tf.done_out),  32'(m_hv && m_hd));
            if (m_hv) begin
                chkv("mon_vout", tf.v_out, m_hw);
                chk("mon_c1", 32'(tf.color_out1), 32'(m_hw[3][23:0]));
                chk("mon_c2", 32'(tf.color_out2), 32'(m_hw[7][23:0]));
                chk("mon_c3", 32'(tf.color_out3), 32'(m_hw[11][23:0]));
            end
        end
    end

    typedef struct {
        logic [31:0] base;
        logic [23:0] rgb;
        int          gap;
        bit          fe5;
        bit          fe14;
        int          hold;
        logic [23:0] e_c1, e_c2, e_c3;
        bit          e_done;
        logic [31:0] e_w0, e_w14;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [31:0] tri_word(vec_t v, int k);
        case (k)
            3:       return {8'h3C, v.rgb};
            7:       return {8'h77, ~v.rgb};
            11:      return {8'hBB, v.rgb ^ 24'h00FFFF};
            default: return v.base + (32'(k) << 16);
        endcase
    endfunction

    function automatic logic [14:0][31:0] tri_vec(vec_t v);
        logic [14:0][31:0] r;
        for (int k = 0; k < 15; k++) r[k] = tri_word(v, k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(logic [31:0] w, bit fe);
        bit r;
        int n;
        n = 0;
        tf.word_valid = 1'b1;
        tf.word_in    = w;
        tf.frame_end  = fe;
        do begin
            @(negedge clock);
            r = tf.word_ready;
            tick();
            n++;
        end while (!r && n < 200);
        if (!r) chk("send_timeout", 32'(r), 32'd1);
        tf.word_valid = 1'b0;
        tf.frame_end  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic send_tri(vec_t v);
        for (int k = 0; k < 15; k++) send(tri_word(v, k), (k == 5 && v.fe5) || (k == 14 && v.fe14));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tf.word_valid = 1'b0;
        tf.word_in    = '0;
        tf.frame_end  = 1'b0;
        tf.stall_in   = 1'b0;

        tbl[0] = '{base:32'h00010000, rgb:24'hFF8000, gap:0, fe5:0, fe14:0, hold:0,
                   e_c1:24'hFF8000, e_c2:24'h007FFF, e_c3:24'hFF7FFF, e_done:0,
                   e_w0:32'h00010000, e_w14:32'h000F0000};
        tbl[1] = '{base:32'h00010000, rgb:24'hFF8000, gap:2, fe5:0, fe14:0, hold:0,
                   e_c1:24'hFF8000, e_c2:24'h007FFF, e_c3:24'hFF7FFF, e_done:0,
                   e_w0:32'h00010000, e_w14:32'h000F0000};
        tbl[2] = '{base:32'hFFFE0000, rgb:24'h123456, gap:0, fe5:1, fe14:0, hold:3,
                   e_c1:24'h123456, e_c2:24'hEDCBA9, e_c3:24'h12CBA9, e_done:0,
                   e_w0:32'hFFFE0000, e_w14:32'h000C0000};
        tbl[3] = '{base:32'h80000000, rgb:24'h00A5FF, gap:1, fe5:0, fe14:1, hold:2,
                   e_c1:24'h00A5FF, e_c2:24'hFF5A00, e_c3:24'h005A00, e_done:1,
                   e_w0:32'h80000000, e_w14:32'h800E0000};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(tf.data_valid), 32'd0);
        chk("rst_done",  32'(tf.done_out),   32'd0);
        chk("rst_count", 32'(tf.tri_count),  32'd0);
        chk("rst_vout0", tf.v_out[0],        32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(tf.word_ready), 32'd1);
        mon_en = 1'b1;

        // Table-driven single triangles
        for (int i = 0; i < 4; i++) begin
            tf.stall_in = 1'b0;
            for (int k = 0; k < 15; k++) begin
                send(tri_word(tbl[i], k), (k == 5 && tbl[i].fe5) || (k == 14 && tbl[i].fe14));
                if (k == 13) chk("tbl_early_valid", 32'(tf.data_valid), 32'd0);
                if (tbl[i].gap > 0 && k < 14) repeat (tbl[i].gap) tick();
            end
            chk("tbl_valid", 32'(tf.data_valid), 32'd1);
            chk("tbl_c1",    32'(tf.color_out1), 32'(tbl[i].e_c1));
            chk("tbl_c2",    32'(tf.color_out2), 32'(tbl[i].e_c2));
            chk("tbl_c3",    32'(tf.color_out3), 32'(tbl[i].e_c3));
            chk("tbl_done",  32'(tf.done_out),   32'(tbl[i].e_done));
            chk("tbl_w0",    tf.v_out[0],        tbl[i].e_w0);
            chk("tbl_w14",   tf.v_out[14],       tbl[i].e_w14);
            chk("tbl_count", 32'(tf.tri_count),  32'(i));
            if (tbl[i].hold > 0) begin
                tf.stall_in = 1'b1;
                repeat (tbl[i].hold) begin
                    tick();
                    chkv("tbl_hold_vout", tf.v_out, tri_vec(tbl[i]));
                    chk("tbl_hold_done", 32'(tf.done_out), 32'(tbl[i].e_done));
                    chk("tbl_hold_valid", 32'(tf.data_valid), 32'd1);
                end
            end
            tf.stall_in = 1'b0;
            tick();
            chk("tbl_post_valid", 32'(tf.data_valid), 32'd0);
            chk("tbl_post_done",  32'(tf.done_out),   32'd0);
            chk("tbl_post_count", 32'(tf.tri_count),  32'(i + 1));
        end

        // Back-to-back triangles under stall
        apply_reset();
        tf.stall_in = 1'b1;
        send_tri(tbl[0]);
        chk("b2b_first_valid", 32'(tf.data_valid), 32'd1);
        send_tri(tbl[2]);
        chk("b2b_full_ready", 32'(tf.word_ready), 32'd0);
        chk("b2b_held_w0",    tf.v_out[0],        32'h00010000);
        repeat (2) tick();
        chk("b2b_still_full", 32'(tf.word_ready), 32'd0);
        tf.stall_in = 1'b0;
        tick();
        chk("b2b_reload_w0",    tf.v_out[0],        32'hFFFE0000);
        chk("b2b_reload_valid", 32'(tf.data_valid), 32'd1);
        chk("b2b_reload_ready", 32'(tf.word_ready), 32'd1);
        chk("b2b_count1",       32'(tf.tri_count),  32'd1);
        tick();
        chk("b2b_count2", 32'(tf.tri_count),  32'd2);
        chk("b2b_empty",  32'(tf.data_valid), 32'd0);

        // Reset mid-triangle while the output is stalled
        apply_reset();
        tf.stall_in = 1'b1;
        send_tri(tbl[3]);
        chk("mid_done_held", 32'(tf.done_out), 32'd1);
        for (int k = 0; k < 7; k++) send($urandom, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tf.data_valid), 32'd0);
        chk("mid_rst_count", 32'(tf.tri_count),  32'd0);
        chk("mid_rst_done",  32'(tf.done_out),   32'd0);
        chk("mid_rst_vout0", tf.v_out[0],        32'd0);
        chk("mid_rst_ready", 32'(tf.word_ready), 32'd1);
        tick();
        reset = 1'b1;
        tf.stall_in = 1'b0;
        send_tri(tbl[0]);
        chk("mid_fresh_valid", 32'(tf.data_valid), 32'd1);
        chkv("mid_fresh_vout", tf.v_out, tri_vec(tbl[0]));
        tick();
        chk("mid_fresh_count", 32'(tf.tri_count), 32'd1);

        // Random traffic, checked by the model each cycle
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            tf.word_valid = ($urandom % 4) != 0;
            tf.word_in    = $urandom;
            tf.frame_end  = 1'($urandom % 2);
            tf.stall_in   = ($urandom % 3) == 0;
            tick();
        end
        tf.word_valid = 1'b0;
        tf.stall_in   = 1'b0;
        repeat (3) tick();

        // Counter wrap at 2^CW transfers
        apply_reset();
        tf.stall_in = 1'b0;
        for (int t = 0; t < 256; t++)
            for (int k = 0; k < 15; k++) send($urandom, 1'b0);
        chk("wrap_pre_count", 32'(tf.tri_count),  32'd255);
        chk("wrap_pre_valid", 32'(tf.data_valid), 32'd1);
        tick();
        chk("wrap_count", 32'(tf.tri_count), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
